matmul_stream_arbiter: RTL

- Shares one 4x4 matmul stream engine between two AXI-Stream requesters, r0 and r1.
- A job is 32 input words from one requester (A row-major, then B row-major) followed by 16 result words returned to the same requester.
- The grant is held for a whole job (feed plus drain). Round-robin between jobs.
- Sits between the user-project stream fabric and the matmul engine.

---
 rtl/matmul_pkg.sv | 29 ++
 rtl/rr_arbiter2.sv | 20 ++
 rtl/matmul_stream_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul stream arbiter and the 4x4 matmul engine:
// arbiter state encoding, job sizes and the word ordering inside a job.
package matmul_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FEED  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

    // Matrix dimension of the engine.
    localparam int MM_DIM       = 4;
    localparam int MM_MAT_WORDS = MM_DIM * MM_DIM;

    // One job: A row-major then B row-major in, C row-major out.
    localparam int MM_IN_WORDS  = 2 * MM_MAT_WORDS;
    localparam int MM_OUT_WORDS = MM_MAT_WORDS;

    // Word offsets of each matrix inside its stream.
    localparam int MM_A_BASE = 0;
    localparam int MM_B_BASE = MM_MAT_WORDS;
    localparam int MM_C_BASE = 0;

    // Stream position of element (row, col) of the matrix starting at base.
    function automatic int mm_word_idx(input int base, input int row, input int col);
        return base + row * MM_DIM + col;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. A lone request always wins; on a tie the
// requester selected by rr_ptr_i wins. Purely combinational, one-hot out.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       rr_ptr_i,
    output logic [1:0] gnt_o
);

    // Resolve the request pair into a one-hot grant.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = rr_ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/matmul_stream_arbiter.sv
// Shares one 4x4 matmul stream engine between two AXI-Stream requesters.
// A grant covers a whole job: pIN_WORDS beats fed in, pOUT_WORDS beats
// drained back to the same requester. Jobs alternate round-robin.
// Both data paths are combinational pass-throughs gated by the FSM state;
// tlast toward the engine and toward the requester is regenerated from the
// beat counters.
// Optional build macro: MATMUL_ARB_TIMEOUT_EN adds a drain watchdog that
// abandons a job after pTIMEOUT cycles with no output handshake.
module matmul_stream_arbiter
    import matmul_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int pIN_WORDS   = MM_IN_WORDS,
    parameter int pOUT_WORDS  = MM_OUT_WORDS,
    parameter int pTIMEOUT    = 1024
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    // requester 0
    input  logic                   ss0_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss0_tdata,
    input  logic                   ss0_tlast,
    output logic                   ss0_tready,
    output logic                   sm0_tvalid,
    output logic [pDATA_WIDTH-1:0] sm0_tdata,
    output logic                   sm0_tlast,
    input  logic                   sm0_tready,
    // requester 1
    input  logic                   ss1_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss1_tdata,
    input  logic                   ss1_tlast,
    output logic                   ss1_tready,
    output logic                   sm1_tvalid,
    output logic [pDATA_WIDTH-1:0] sm1_tdata,
    output logic                   sm1_tlast,
    input  logic                   sm1_tready,
    // engine
    output logic                   eng_ss_tvalid,
    output logic [pDATA_WIDTH-1:0] eng_ss_tdata,
    output logic                   eng_ss_tlast,
    input  logic                   eng_ss_tready,
    input  logic                   eng_sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] eng_sm_tdata,
    input  logic                   eng_sm_tlast,
    output logic                   eng_sm_tready,
    // status
    output logic [1:0]             grant,
    output logic                   busy,
    output logic                   err_tlast,
    output logic                   timeout
);

    localparam int              CW       = $clog2(pIN_WORDS) + 1;
    localparam logic [CW-1:0]   IN_LAST  = CW'(pIN_WORDS - 1);
    localparam logic [CW-1:0]   OUT_LAST = CW'(pOUT_WORDS - 1);

    arb_state_e    state_q;
    logic [1:0]    grant_q;
    logic          rr_ptr_q;
    logic [CW-1:0] in_cnt_q;
    logic [CW-1:0] out_cnt_q;
    logic          err_q;

    logic [1:0]    pick;
    logic          own1;
    logic          in_last;
    logic          out_last;
    logic          in_hs;
    logic          out_hs;
    logic          req_tlast;

    // Engine output tlast is ignored (the count governs); pTIMEOUT only
    // matters with the watchdog built in.
    logic          unused_ok;
    assign unused_ok = eng_sm_tlast ^ (pTIMEOUT > 0);

    rr_arbiter2 u_rr (
        .req_i    ({ss1_tvalid, ss0_tvalid}),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (pick)
    );

    assign own1      = grant_q[1];
    assign in_last   = (in_cnt_q == IN_LAST);
    assign out_last  = (out_cnt_q == OUT_LAST);
    assign in_hs     = (state_q == ARB_FEED) && eng_ss_tvalid && eng_ss_tready;
    assign out_hs    = (state_q == ARB_DRAIN) && eng_sm_tvalid && eng_sm_tready;
    assign req_tlast = own1 ? ss1_tlast : ss0_tlast;

    assign grant     = grant_q;
    assign busy      = (state_q != ARB_IDLE);
    assign err_tlast = err_q;

`ifdef MATMUL_ARB_TIMEOUT_EN
    localparam int            TW      = $clog2(pTIMEOUT) + 1;
    localparam logic [TW-1:0] WD_LAST = TW'(pTIMEOUT - 1);
    logic [TW-1:0] wd_q;
    logic          to_q;
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    // Steer the owner's streams to/from the engine; everything else idles at 0.
    always_comb begin
        eng_ss_tvalid = 1'b0;
        eng_ss_tdata  = '0;
        eng_ss_tlast  = 1'b0;
        ss0_tready    = 1'b0;
        ss1_tready    = 1'b0;
        eng_sm_tready = 1'b0;
        sm0_tvalid    = 1'b0;
        sm0_tdata     = '0;
        sm0_tlast     = 1'b0;
        sm1_tvalid    = 1'b0;
        sm1_tdata     = '0;
        sm1_tlast     = 1'b0;
        if (state_q == ARB_FEED) begin
            eng_ss_tvalid = own1 ? ss1_tvalid : ss0_tvalid;
            eng_ss_tdata  = own1 ? ss1_tdata  : ss0_tdata;
            eng_ss_tlast  = in_last;
            ss0_tready    = !own1 && eng_ss_tready;
            ss1_tready    = own1 && eng_ss_tready;
        end
        if (state_q == ARB_DRAIN) begin
            eng_sm_tready = own1 ? sm1_tready : sm0_tready;
            if (own1) begin
                sm1_tvalid = eng_sm_tvalid;
                sm1_tdata  = eng_sm_tdata;
                sm1_tlast  = out_last;
            end else begin
                sm0_tvalid = eng_sm_tvalid;
                sm0_tdata  = eng_sm_tdata;
                sm0_tlast  = out_last;
            end
        end
    end

    // Job FSM: grant in IDLE, count input beats in FEED, count results in DRAIN.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q   <= ARB_IDLE;
            grant_q   <= 2'b00;
            rr_ptr_q  <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
`ifdef MATMUL_ARB_TIMEOUT_EN
            wd_q      <= '0;
            to_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick != 2'b00) begin
                        grant_q  <= pick;
                        in_cnt_q <= '0;
                        state_q  <= ARB_FEED;
                    end
                end
                ARB_FEED: begin
                    if (in_hs) begin
                        in_cnt_q <= in_cnt_q + 1'b1;
                        if (req_tlast != in_last)
                            err_q <= 1'b1;
                        if (in_last) begin
                            out_cnt_q <= '0;
                            state_q   <= ARB_DRAIN;
`ifdef MATMUL_ARB_TIMEOUT_EN
                            wd_q      <= '0;
`endif
                        end
                    end
                end
                ARB_DRAIN: begin
                    if (out_hs) begin
                        out_cnt_q <= out_cnt_q + 1'b1;
                        if (out_last) begin
                            state_q  <= ARB_IDLE;
                            grant_q  <= 2'b00;
                            rr_ptr_q <= grant_q[0];
                        end
`ifdef MATMUL_ARB_TIMEOUT_EN
                        wd_q <= '0;
                    end else if (wd_q == WD_LAST) begin
                        // Engine stopped producing: give up on this job.
                        to_q     <= 1'b1;
                        wd_q     <= '0;
                        state_q  <= ARB_IDLE;
                        grant_q  <= 2'b00;
                        rr_ptr_q <= grant_q[0];
                    end else begin
                        wd_q <= wd_q + 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule
